// File: rtl/uart_note_parser.sv
// Purpose : decodes 5-byte note frames (SYNC, CMD, NOTE, VEL, CHK) from a UART byte stream.
// Latency : o_Note_DV / o_Err are registered, one cycle after the CHK byte's i_Rx_DV.
// Backpressure: none; accepts one byte per clock, no dead cycles between frames.
//
// Ports:
//   i_Clock, i_Rst_L       - clock, synchronous active-low reset
//   i_Rx_DV, i_Rx_Byte     - received-byte strobe and data
//   o_Note_DV              - one-cycle strobe: valid frame decoded
//   o_Note_On/o_Note/o_Velocity - last valid frame's fields (held between frames)
//   o_Err, o_Err_Count     - one-cycle reject strobe, saturating reject count
// Optional: define PARSER_TIMEOUT_EN to abort a partial frame after TIMEOUT_CLKS
// clocks without a byte; without it a partial frame waits indefinitely.
module uart_note_parser #(
  parameter int         TIMEOUT_CLKS = 17400,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Note_DV,
  output logic       o_Note_On,
  output logic [6:0] o_Note,
  output logic [6:0] o_Velocity,
  output logic       o_Err,
  output logic [7:0] o_Err_Count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_NOTE = 3'd2,
    S_VEL  = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_cmd;
  logic [7:0] r_note;
  logic [7:0] r_vel;
  logic       w_chk_stb;
  logic       w_frame_ok;
  logic       w_timeout;
  logic       w_reject;

  logic       r_note_dv;
  logic       r_note_on;
  logic [6:0] r_note_out;
  logic [6:0] r_vel_out;
  logic       r_err;
  logic [7:0] r_err_count;

  // The counter needs at least two distinct values to mean anything.
  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("uart_note_parser: TIMEOUT_CLKS must be at least 2");
  end

  // The frame check uses the live CHK byte so the verdict is ready in the
  // same cycle it arrives and can be registered straight to the outputs.
  assign w_frame_ok = ((r_cmd == 8'h01) || (r_cmd == 8'h02)) &&
                      !r_note[7] && !r_vel[7] &&
                      (i_Rx_Byte == (r_cmd ^ r_note ^ r_vel));

  assign w_reject = (w_chk_stb && !w_frame_ok) || w_timeout;

  // A byte always wins over a timeout that expires in the same cycle,
  // because w_timeout already excludes i_Rx_DV.
  always_comb begin
    w_next_state = r_state;
    w_chk_stb    = 1'b0;
    if (i_Rx_DV) begin
      case (r_state)
        S_IDLE: if (i_Rx_Byte == SYNC_BYTE) w_next_state = S_CMD;
        S_CMD:  w_next_state = S_NOTE;
        S_NOTE: w_next_state = S_VEL;
        S_VEL:  w_next_state = S_CHK;
        S_CHK: begin
          w_next_state = S_IDLE;
          w_chk_stb    = 1'b1;
        end
        default: w_next_state = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_next_state = S_IDLE;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_state <= S_IDLE;
      r_cmd   <= 8'h00;
      r_note  <= 8'h00;
      r_vel   <= 8'h00;
    end else begin
      r_state <= w_next_state;
      if (i_Rx_DV) begin
        if (r_state == S_CMD)  r_cmd  <= i_Rx_Byte;
        if (r_state == S_NOTE) r_note <= i_Rx_Byte;
        if (r_state == S_VEL)  r_vel  <= i_Rx_Byte;
      end
    end
  end

`ifdef PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);

  logic [TW-1:0] r_timer;

  assign w_timeout = (r_state != S_IDLE) && !i_Rx_DV &&
                     (r_timer == TW'(TIMEOUT_CLKS - 1));

  // Counts clocks since the last byte while a frame is in progress.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_timer <= '0;
    end else if ((r_state == S_IDLE) || i_Rx_DV || w_timeout) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      r_note_dv   <= 1'b0;
      r_note_on   <= 1'b0;
      r_note_out  <= 7'd0;
      r_vel_out   <= 7'd0;
      r_err       <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      r_note_dv <= w_chk_stb && w_frame_ok;
      r_err     <= w_reject;
      if (w_chk_stb && w_frame_ok) begin
        r_note_on  <= (r_cmd == 8'h01);
        r_note_out <= r_note[6:0];
        r_vel_out  <= r_vel[6:0];
      end
      if (w_reject && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign o_Note_DV   = r_note_dv;
  assign o_Note_On   = r_note_on;
  assign o_Note      = r_note_out;
  assign o_Velocity  = r_vel_out;
  assign o_Err       = r_err;
  assign o_Err_Count = r_err_count;

endmodule

// File: tb/tb_uart_note_parser.sv
// Purpose : self-checking bench for uart_note_parser against a frame-level reference model.
// Latency : model predicts outputs one cycle after each sampled byte.
// Backpressure: none; stimulus drives bytes back-to-back or with random gaps.
module tb_uart_note_parser;

  localparam int         T    = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       note_dv, note_on, err;
  logic [6:0] note, vel;
  logic [7:0] err_cnt;

  uart_note_parser #(.TIMEOUT_CLKS(T), .SYNC_BYTE(SYNC)) dut (
    .i_Clock    (clk),
    .i_Rst_L    (rst_n),
    .i_Rx_DV    (rx_dv),
    .i_Rx_Byte  (rx_byte),
    .o_Note_DV  (note_dv),
    .o_Note_On  (note_on),
    .o_Note     (note),
    .o_Velocity (vel),
    .o_Err      (err),
    .o_Err_Count(err_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int dv_pulses = 0;
  int err_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects bytes of a frame once SYNC is seen, judges
  // the frame when five bytes are in hand.
  int         n = 0;
  logic [7:0] fr [5];
  longint     cyc = 0;
  longint     last = 0;
  bit         started = 0;
  logic       m_dv = 0, m_err = 0, m_on = 0;
  logic [6:0] m_note = 0, m_vel = 0;
  logic [7:0] m_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    started = 1;
    m_dv = 0;
    m_err = 0;
    if (!rst_n) begin
      n = 0;
      m_on = 0;
      m_note = 0;
      m_vel = 0;
      m_cnt = 0;
    end else if (rx_dv) begin
      last = cyc;
      if (n == 0) begin
        if (rx_byte == SYNC) begin
          fr[0] = rx_byte;
          n = 1;
        end
      end else begin
        fr[n] = rx_byte;
        n++;
        if (n == 5) begin
          n = 0;
          if ((fr[1] == 8'h01 || fr[1] == 8'h02) && fr[2] < 8'h80 && fr[3] < 8'h80 &&
              fr[4] == (fr[1] ^ fr[2] ^ fr[3])) begin
            m_dv = 1;
            m_on = (fr[1] == 8'h01);
            m_note = fr[2][6:0];
            m_vel = fr[3][6:0];
          end else begin
            m_err = 1;
            if (m_cnt != 8'hFF) m_cnt++;
          end
        end
      end
    end
`ifdef PARSER_TIMEOUT_EN
    else if (n > 0 && cyc - last == T) begin
      n = 0;
      m_err = 1;
      if (m_cnt != 8'hFF) m_cnt++;
    end
`endif
  end

  always @(negedge clk) begin
    if (started) begin
      check("note_dv", note_dv, m_dv);
      check("err", err, m_err);
      check("note_on", note_on, m_on);
      check("note", note, m_note);
      check("velocity", vel, m_vel);
      check("err_count", err_cnt, m_cnt);
      check("dv_err_exclusive", note_dv & err, 0);
      if (note_dv) dv_pulses++;
      if (err) err_pulses++;
    end
  end

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_dv = 1'b1;
    rx_byte = b;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      rx_dv = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b0, b1, b2, b3, b4);
    put(b0); put(b1); put(b2); put(b3); put(b4);
    idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0;
    logic [7:0] cmd, nb, vb, cb;

    // Reset, with a byte strobed during reset that must be ignored.
    repeat (2) @(negedge clk);
    rx_dv = 1'b1; rx_byte = SYNC;
    @(negedge clk);
    rx_dv = 1'b0;
    check("reset_count", err_cnt, 8'h00);
    check("reset_note", note, 7'h00);
    check("reset_dv", note_dv, 1'b0);
    rst_n = 1'b1;
    d0 = dv_pulses; e0 = err_pulses;
    put(8'h01); put(8'h3C); put(8'h64); put(8'h59);
    idle(2);
    check("dv_during_reset_ignored", dv_pulses - d0, 0);
    check("dv_during_reset_no_err", err_pulses - e0, 0);

    // Single valid note-on.
    frame(8'hA5, 8'h01, 8'h3C, 8'h64, 8'h59);
    check("lit1_dv", note_dv, 1'b1);
    check("lit1_on", note_on, 1'b1);
    check("lit1_note", note, 7'h3C);
    check("lit1_vel", vel, 7'h64);
    idle(1);

    // Back-to-back frames, no gap.
    d0 = dv_pulses;
    put(8'hA5); put(8'h02); put(8'h3C); put(8'h00); put(8'h3E);
    put(8'hA5); put(8'h01); put(8'h40); put(8'h7F); put(8'h3E);
    idle(2);
    check("b2b_pulses", dv_pulses - d0, 2);
    check("b2b_on", note_on, 1'b1);
    check("b2b_note", note, 7'h40);
    check("b2b_vel", vel, 7'h7F);

    // Bad checksum: error, outputs held.
    frame(8'hA5, 8'h01, 8'h3C, 8'h64, 8'h58);
    check("badchk_err", err, 1'b1);
    check("badchk_count", err_cnt, 8'h01);
    check("badchk_note_held", note, 7'h40);
    check("badchk_vel_held", vel, 7'h7F);
    idle(1);
    e0 = err_pulses;
    put(8'h00); put(8'hFF); put(8'h12);
    idle(2);
    check("junk_no_err", err_pulses - e0, 0);

    // Reset mid-frame discards the partial frame.
    put(8'hA5); put(8'h01);
    @(negedge clk);
    rst_n = 1'b0; rx_dv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = dv_pulses; e0 = err_pulses;
    put(8'h3C); put(8'h64); put(8'h59);
    idle(2);
    check("midreset_no_dv", dv_pulses - d0, 0);
    check("midreset_no_err", err_pulses - e0, 0);
    check("midreset_count", err_cnt, 8'h00);

    // Saturation of the error counter.
    repeat (255) frame(8'hA5, 8'h03, 8'h10, 8'h10, 8'h03);
    check("sat_255", err_cnt, 8'hFF);
    frame(8'hA5, 8'h03, 8'h10, 8'h10, 8'h03);
    check("sat_hold", err_cnt, 8'hFF);
    check("sat_err_pulse", err, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: put(8'($urandom));
        1: idle($urandom_range(1, 3));
        2: begin
          @(negedge clk);
          rst_n = 1'b0;
          rx_dv = 1'($urandom_range(0, 1));
          rx_byte = 8'($urandom);
          @(negedge clk);
          rst_n = 1'b1;
          rx_dv = 1'b0;
        end
        default: begin
          case ($urandom_range(0, 4))
            0: cmd = 8'($urandom);
            1, 2: cmd = 8'h01;
            default: cmd = 8'h02;
          endcase
          nb = 8'($urandom);
          vb = 8'($urandom);
          if ($urandom_range(0, 4) != 0) nb[7] = 1'b0;
          if ($urandom_range(0, 4) != 0) vb[7] = 1'b0;
          cb = cmd ^ nb ^ vb;
          if ($urandom_range(0, 4) == 0) cb = cb ^ 8'($urandom_range(1, 255));
          put(SYNC);
          put(cmd);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
          put(nb);
          put(vb);
          put(cb);
          if ($urandom_range(0, 1) == 0) idle(1);
        end
      endcase
    end
    idle(2);

`ifdef PARSER_TIMEOUT_EN
    // Partial frame times out, then a full frame decodes.
    put(8'hA5); put(8'h01);
    idle(T + 1);
    check("timeout_err", err, 1'b1);
    idle(1);
    frame(8'hA5, 8'h02, 8'h11, 8'h22, 8'h31);
    check("after_timeout_dv", note_dv, 1'b1);
    check("after_timeout_note", note, 7'h11);
    idle(1);
    // A byte landing on the expiry cycle is accepted.
    e0 = err_pulses;
    put(8'hA5);
    idle(T - 1);
    put(8'h01); put(8'h3C); put(8'h64); put(8'h59);
    idle(1);
    check("expiry_byte_wins_dv", note_dv, 1'b1);
    idle(1);
    check("expiry_byte_wins_no_err", err_pulses - e0, 0);
`endif

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_note_parser.md
UART_NOTE_PARSER -- requirements
Module: uart_note_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 17400, giving the inter-byte timeout in clocks (20 bit-times at CLKS_PER_BIT=870).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, giving the frame start marker.
REQ-003 SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_Rst_L, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port i_Rx_DV, input, 1 bit: one-cycle strobe that a received byte is valid.
REQ-006 SHALL have port i_Rx_Byte, input, 8 bits: the received byte, sampled only when i_Rx_DV=1.
REQ-007 SHALL have port o_Note_DV, output, 1 bit: one-cycle strobe that a valid frame was decoded.
REQ-008 SHALL have port o_Note_On, output, 1 bit: 1 = note-on, 0 = note-off.
REQ-009 SHALL have port o_Note, output, 7 bits: note number.
REQ-010 SHALL have port o_Velocity, output, 7 bits: velocity.
REQ-011 SHALL have port o_Err, output, 1 bit: one-cycle strobe that a frame was rejected.
REQ-012 SHALL have port o_Err_Count, output, 8 bits: count of rejected frames, saturating.

Function
REQ-013 Frame format SHALL be SYNC_BYTE, CMD, NOTE, VEL, CHK, with CHK = CMD ^ NOTE ^ VEL.
REQ-014 States SHALL be S_IDLE, S_CMD, S_NOTE, S_VEL, S_CHK; only a cycle with i_Rx_DV=1 advances the state.
REQ-015 In S_IDLE, a byte equal to SYNC_BYTE SHALL move the state to S_CMD; any other byte SHALL be discarded silently, with no o_Err.
REQ-016 S_CMD, S_NOTE and S_VEL SHALL capture their byte into internal holding registers and advance in sequence; S_CHK SHALL compare its byte with the XOR and return to S_IDLE.
REQ-017 SYNC_BYTE received mid-frame SHALL be treated as ordinary data; there is no resync.
REQ-018 A frame SHALL be valid only if all four conditions hold: CMD is 8'h01 or 8'h02, NOTE[7]=0, VEL[7]=0, and CHK matches.
REQ-019 Valid frame: one cycle after the CHK byte's i_Rx_DV, o_Note_DV=1 for exactly one cycle.
REQ-020 On that same valid frame, o_Note_On SHALL be 1 when CMD=8'h01, and o_Note=NOTE[6:0], o_Velocity=VEL[6:0].
REQ-021 o_Note_On, o_Note and o_Velocity SHALL hold their values until the next valid frame; invalid frames SHALL not change them.
REQ-022 Invalid frame: one cycle after the CHK byte's i_Rx_DV, o_Err=1 for one cycle, and o_Err_Count SHALL increment, saturating at 8'hFF.
REQ-023 o_Note_DV and o_Err SHALL never be high in the same cycle.
REQ-024 Back-to-back frames SHALL be accepted with no dead cycles: a SYNC_BYTE arriving the cycle after CHK SHALL be accepted.
REQ-025 Throughput SHALL be at least one byte per clock, although the upstream receiver delivers at most one byte per ~10*CLKS_PER_BIT clocks.

Reset
REQ-026 While i_Rst_L=0 at a rising edge, the state SHALL go to S_IDLE and holding registers SHALL clear.
REQ-027 During reset, o_Note_DV=0, o_Note_On=0, o_Note=0, o_Velocity=0, o_Err=0, o_Err_Count=0, and the timeout counter SHALL be 0.
REQ-028 Reset mid-frame SHALL discard the partial frame without asserting o_Err.
REQ-029 A byte with i_Rx_DV=1 during reset SHALL be ignored.

Configuration
REQ-030 Macro PARSER_TIMEOUT_EN SHALL control the inter-byte timeout.
REQ-031 With PARSER_TIMEOUT_EN defined: in states other than S_IDLE, a counter SHALL increment each clock and clear on every i_Rx_DV.
REQ-032 With PARSER_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CLKS-1 without i_Rx_DV, the block SHALL abort to S_IDLE, pulse o_Err next cycle and increment o_Err_Count.
REQ-033 With PARSER_TIMEOUT_EN defined: if i_Rx_DV coincides with the expiry cycle, the byte SHALL win; it is accepted and no timeout fires.
REQ-034 Without PARSER_TIMEOUT_EN: no counter logic SHALL exist, and a partial frame SHALL wait indefinitely.

Verification
REQ-035 Send A5 01 3C 64 59 -> one cycle after the last DV, o_Note_DV=1, o_Note_On=1, o_Note=0x3C, o_Velocity=0x64.
REQ-036 Send A5 02 3C 00 3E, then A5 01 40 7F 3E back-to-back -> two o_Note_DV pulses; final outputs are o_Note_On=1, o_Note=0x40, o_Velocity=0x7F.
REQ-037 Send A5 01 3C 64 58 (bad CHK) -> o_Err pulse, o_Err_Count=1, outputs unchanged from the prior frame; send 00 FF 12 -> no o_Err.
REQ-038 Send A5 03 10 10 03 (bad CMD), repeated 256 times -> o_Err_Count saturates at 0xFF.
REQ-039 Send A5 01, then deassert i_Rst_L for 1 cycle, then send 3C 64 59 -> no o_Note_DV and no o_Err.
REQ-040 With PARSER_TIMEOUT_EN: send A5 01, then idle TIMEOUT_CLKS clocks -> o_Err pulse and return to S_IDLE; a following full valid frame decodes normally.
